cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter that shares the single ALU-side common data bus (CDB) between several result producers: ALU reservation station, branch unit, and spare. The CDB feeds the reorder buffer and the reservation stations. Each cycle it grants at most one requester and drives that requester's result onto the registered CDB one cycle later. On a misbranch flush it drops all pending broadcasts so that no squashed result reaches the reorder buffer.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters (2..8).
- `ROB_W`, default 4: ROB tag width. Tag 0 (`ZERO_ROB`) means "no broadcast".
- `DATA_W`, default 32: value and jump-address width.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ena` input 1: global enable. When low, nothing is granted.
- `in_flush` input 1: misbranch flush, from the reorder buffer's `out_misbranch`.
- `in_req_valid` input NUM_REQ: requester i holds a result.
- `in_req_rob_tag` input NUM_REQ*ROB_W: packed tags, requester i at `[i*ROB_W +: ROB_W]`.
- `in_req_value` input NUM_REQ*DATA_W: packed result values.
- `in_req_isjump` input NUM_REQ: branch taken / jump flag.
- `in_req_jump_addr` input NUM_REQ*DATA_W: packed resolved targets.
- `out_req_ready` input→output NUM_REQ: one-hot grant, combinational.
- `out_cdb_rob_tag` output ROB_W: broadcast tag.
- `out_cdb_value` output DATA_W: broadcast value.
- `out_cdb_isjump` output 1: broadcast jump flag.
- `out_cdb_jump_addr` output DATA_W: broadcast jump target.
- `out_cdb_isload` output 1: tied 0. Loads use the separate LS CDB.

## Operation
- **Eligibility.** Requester i is eligible when `in_req_valid[i]=1` and its tag is not 0. A valid request with tag 0 is ignored and never granted.
- **Handshake.** A requester holds valid and its payload stable until it sees `out_req_ready[i]=1`. The transfer happens on the rising edge where valid and ready are both high.
- **Arbitration.** A round-robin pointer `rr_ptr` (width clog2(NUM_REQ), reset 0) marks the highest-priority index. The search order is rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ. The first eligible requester is granted.
- **Pointer update.** After a grant to index g, `rr_ptr` becomes g+1, or 0 when g = NUM_REQ-1. With no grant, `rr_ptr` is unchanged.
- **No grant.** All `out_req_ready` bits are 0 whenever any of these hold: `rst=1`, `ena=0`, `in_flush=1`, or no requester is eligible.
- **Broadcast register.**
  - After a grant, the next edge loads the granted payload into the `out_cdb_*` registers.
  - With no grant, the next edge loads tag 0, value 0, isjump 0 and jump_addr 0. Every broadcast therefore lasts exactly one cycle.
- **Flush.** During a cycle with `in_flush=1`:
  - no grant is issued;
  - the output registers load the zero/bubble values;
  - `rr_ptr` is held.

  Requesters are responsible for dropping their own squashed entries. The arbiter keeps no storage of its own.
- **Reset values.** All `out_cdb_*` are 0, `rr_ptr` is 0, `out_req_ready` is 0. Asserting `rst` mid-broadcast clears the outputs immediately, asynchronously.

## Timing
- Grant latency is 0 cycles: `out_req_ready` is a combinational function of `in_req_valid`, the tags, `rr_ptr`, `ena` and `in_flush`.
- Broadcast latency is 1 cycle: a grant in cycle t puts the tag on the CDB in cycle t+1 for one cycle only.
- Throughput is one broadcast per cycle. Back-to-back grants to different requesters are allowed.
- Fairness: with all NUM_REQ requesters continuously eligible, each one is granted exactly once every NUM_REQ cycles. A continuously eligible requester waits at most NUM_REQ-1 grant cycles.
- `ena` low for k cycles produces k bubble cycles on the CDB. Arbitration resumes from the held `rr_ptr`.
- `in_flush` coincident with a cycle-t grant request: the flush wins and nothing is granted. A broadcast already registered at t (granted at t-1) is still driven at t. The reorder buffer discards it via its own flush.

## Structure
- The shared constants package (`constant.v`) holds `ZERO_ROB`, `ZERO_DATA`, `TRUE`/`FALSE` and `ROB_WIDTH`/`DATA_WIDTH`. `ROB_W` and `DATA_W` default to those values.
- Sub-module `rr_arbiter`: parameter `N`, with ports `clk`, `rst`, `req[N]`, `adv`, `grant[N]` one-hot. It contains the pointer and the rotate/priority-encode logic; `adv` updates the pointer.
- `cdb_arbiter` contains the eligibility masking, the grant gating (ena/flush), the payload mux and the output registers.

## Test plan
- **Single requester.** Requester 1 valid, tag 5, value 0x0000_00AA, for one cycle. Expect `out_req_ready`=3'b010 that cycle, then next cycle `out_cdb_rob_tag`=5 and value 0xAA, then tag 0 the following cycle. `rr_ptr` becomes 2.
- **Round-robin fairness.** All three valid for 6 cycles with distinct tags 1/2/3. Expect grant order 0,1,2,0,1,2 from reset, and CDB tags 1,2,3,1,2,3 one cycle behind.
- **Tag-0 filter.** Requester 0 valid with tag 0, requester 2 valid with tag 7. Expect the grant to go to 2, and requester 0 never granted.
- **Flush.** Requesters 0 and 1 valid; assert `in_flush` for 1 cycle. Expect ready=0 and the next-cycle CDB tag=0, with `rr_ptr` unchanged. The cycle after the flush, grant resumes at the held pointer.
- **Enable and async reset.**
  - `ena`=0 for 3 cycles with all requesters valid: expect 3 bubble cycles (tag 0), then normal order.
  - Assert `rst` mid-cycle while the CDB shows tag 4: expect outputs 0 before the next edge and `rr_ptr`=0.
- **Hold-under-backpressure.** Requesters 0 and 2 continuously valid for 4 cycles. Expect each to see ready every second cycle, and each payload to appear on the CDB exactly once per grant.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths and bubble constants for the ALU-side common data bus
package cdb_arbiter_pkg;
   localparam int ROB_WIDTH = 4;
   localparam int DATA_WIDTH = 32;
   localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;
   localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
   localparam logic TRUE = 1'b1;
   localparam logic FALSE = 1'b0;
endpackage

// File: rtl/cdb_arbiter_rr.sv
// rr_arbiter: one-hot round-robin grant; the pointer names the highest-priority index
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         adv,
   output logic [N-1:0] grant
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   logic [PW-1:0] ptr, idx, nxt_ptr;
   logic found;
   always_comb begin
      grant = '0;
      nxt_ptr = ptr;
      found = 1'b0;
      idx = ptr;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found = 1'b1;
            grant[idx] = 1'b1;
            nxt_ptr = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
         end
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr <= '0;
      else if (adv) ptr <= nxt_ptr;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the registered ALU CDB among result producers, one broadcast per cycle
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ROB_W = ROB_WIDTH,
   parameter int DATA_W = DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena,
   input  logic                    in_flush,
   input  logic [NUM_REQ-1:0]        in_req_valid,
   input  logic [NUM_REQ*ROB_W-1:0]  in_req_rob_tag,
   input  logic [NUM_REQ*DATA_W-1:0] in_req_value,
   input  logic [NUM_REQ-1:0]        in_req_isjump,
   input  logic [NUM_REQ*DATA_W-1:0] in_req_jump_addr,
   output logic [NUM_REQ-1:0]        out_req_ready,
   output logic [ROB_W-1:0]          out_cdb_rob_tag,
   output logic [DATA_W-1:0]         out_cdb_value,
   output logic                      out_cdb_isjump,
   output logic [DATA_W-1:0]         out_cdb_jump_addr,
   output logic                      out_cdb_isload
);
   logic [NUM_REQ-1:0] elig, grant;
   logic [ROB_W-1:0] tag_n;
   logic [DATA_W-1:0] value_n, jaddr_n;
   logic isjump_n, open;
   // Tag 0 is the bubble marker, so such a request can never reach the bus
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_REQ; i++)
         elig[i] = in_req_valid[i] && (in_req_rob_tag[i*ROB_W +: ROB_W] != ROB_W'(ZERO_ROB));
   end
   assign open = ena && !in_flush && !rst;
   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .clk   (clk),
      .rst   (rst),
      .req   (elig & {NUM_REQ{open}}),
      .adv   (|grant),
      .grant (grant)
   );
   assign out_req_ready = grant;
   always_comb begin
      tag_n = '0;
      value_n = '0;
      isjump_n = 1'b0;
      jaddr_n = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i]) begin
            tag_n = in_req_rob_tag[i*ROB_W +: ROB_W];
            value_n = in_req_value[i*DATA_W +: DATA_W];
            isjump_n = in_req_isjump[i];
            jaddr_n = in_req_jump_addr[i*DATA_W +: DATA_W];
         end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_cdb_rob_tag <= '0;
         out_cdb_value <= '0;
         out_cdb_isjump <= 1'b0;
         out_cdb_jump_addr <= '0;
      end else begin
         out_cdb_rob_tag <= tag_n;
         out_cdb_value <= value_n;
         out_cdb_isjump <= isjump_n;
         out_cdb_jump_addr <= jaddr_n;
      end
   assign out_cdb_isload = FALSE;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors with hand-computed grants and CDB contents
module tb_cdb_arbiter;
   localparam int N = 3, RW = 4, DW = 32;
   logic clk = 1'b0, rst = 1'b1, ena = 1'b1, in_flush = 1'b0;
   logic [N-1:0] valid = '0, isjump = '0;
   logic [N*RW-1:0] tags = '0;
   logic [N*DW-1:0] vals = '0, jaddr = '0;
   logic [N-1:0] ready;
   logic [RW-1:0] cdb_tag;
   logic [DW-1:0] cdb_value, cdb_jaddr;
   logic cdb_isjump, cdb_isload;
   int errors = 0, checks = 0;

   cdb_arbiter #(.NUM_REQ(N), .ROB_W(RW), .DATA_W(DW)) dut (
      .clk               (clk),
      .rst               (rst),
      .ena               (ena),
      .in_flush          (in_flush),
      .in_req_valid      (valid),
      .in_req_rob_tag    (tags),
      .in_req_value      (vals),
      .in_req_isjump     (isjump),
      .in_req_jump_addr  (jaddr),
      .out_req_ready     (ready),
      .out_cdb_rob_tag   (cdb_tag),
      .out_cdb_value     (cdb_value),
      .out_cdb_isjump    (cdb_isjump),
      .out_cdb_jump_addr (cdb_jaddr),
      .out_cdb_isload    (cdb_isload)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [RW-1:0] t, input logic [DW-1:0] d);
      valid[i] = v;
      tags[i*RW +: RW] = t;
      vals[i*DW +: DW] = d;
   endtask

   task automatic clear_all();
      valid = '0;
      isjump = '0;
      jaddr = '0;
   endtask

   // Checks the combinational grant and the CDB mid-cycle, then advances one edge
   task automatic cyc(input string name, input logic [N-1:0] rdy, input logic [RW-1:0] t, input logic [DW-1:0] d);
      @(negedge clk);
      chk({name, ".ready"}, 32'(ready), 32'(rdy));
      chk({name, ".tag"}, 32'(cdb_tag), 32'(t));
      chk({name, ".value"}, cdb_value, d);
      @(posedge clk);
      #1;
   endtask

   initial begin
      set_req(0, 1'b1, 4'd1, 32'h11);
      set_req(1, 1'b1, 4'd2, 32'h22);
      set_req(2, 1'b1, 4'd3, 32'h33);
      #2;
      chk("rst.ready", 32'(ready), 32'h0);
      chk("rst.tag", 32'(cdb_tag), 32'h0);
      chk("rst.value", cdb_value, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_all();
      // Single requester
      set_req(1, 1'b1, 4'd5, 32'hAA);
      cyc("single", 3'b010, 4'd0, 32'h0);
      clear_all();
      cyc("single_bc", 3'b000, 4'd5, 32'hAA);
      cyc("single_end", 3'b000, 4'd0, 32'h0);
      // Pointer now 2: all valid grants requester 2 first
      set_req(0, 1'b1, 4'd1, 32'h11);
      set_req(1, 1'b1, 4'd2, 32'h22);
      set_req(2, 1'b1, 4'd4, 32'h44);
      cyc("ptr2", 3'b100, 4'd0, 32'h0);
      chk("pre_rst.tag", 32'(cdb_tag), 32'h4);
      #2;
      rst = 1'b1;
      #1;
      chk("arst.tag", 32'(cdb_tag), 32'h0);
      chk("arst.value", cdb_value, 32'h0);
      chk("arst.ready", 32'(ready), 32'h0);
      set_req(2, 1'b1, 4'd3, 32'h33);
      @(posedge clk);
      #1;
      rst = 1'b0;
      // Fairness from reset pointer 0
      cyc("rr0", 3'b001, 4'd0, 32'h0);
      cyc("rr1", 3'b010, 4'd1, 32'h11);
      cyc("rr2", 3'b100, 4'd2, 32'h22);
      cyc("rr3", 3'b001, 4'd3, 32'h33);
      cyc("rr4", 3'b010, 4'd1, 32'h11);
      cyc("rr5", 3'b100, 4'd2, 32'h22);
      clear_all();
      cyc("rr_end", 3'b000, 4'd3, 32'h33);
      // Tag-0 filter, pointer 0
      set_req(0, 1'b1, 4'd0, 32'h55);
      set_req(2, 1'b1, 4'd7, 32'h77);
      cyc("t0a", 3'b100, 4'd0, 32'h0);
      valid[2] = 1'b0;
      cyc("t0b", 3'b000, 4'd7, 32'h77);
      cyc("t0c", 3'b000, 4'd0, 32'h0);
      clear_all();
      // Flush, pointer 0
      set_req(0, 1'b1, 4'd1, 32'h11);
      set_req(1, 1'b1, 4'd2, 32'h22);
      in_flush = 1'b1;
      cyc("flush", 3'b000, 4'd0, 32'h0);
      in_flush = 1'b0;
      cyc("fl_resume", 3'b001, 4'd0, 32'h0);
      valid[0] = 1'b0;
      cyc("fl_r1", 3'b010, 4'd1, 32'h11);
      clear_all();
      cyc("fl_end", 3'b000, 4'd2, 32'h22);
      // Enable low for 3 cycles, pointer 2
      set_req(0, 1'b1, 4'd1, 32'h11);
      set_req(1, 1'b1, 4'd2, 32'h22);
      set_req(2, 1'b1, 4'd3, 32'h33);
      ena = 1'b0;
      cyc("ena0", 3'b000, 4'd0, 32'h0);
      cyc("ena1", 3'b000, 4'd0, 32'h0);
      cyc("ena2", 3'b000, 4'd0, 32'h0);
      ena = 1'b1;
      cyc("ena_r0", 3'b100, 4'd0, 32'h0);
      cyc("ena_r1", 3'b001, 4'd3, 32'h33);
      cyc("ena_r2", 3'b010, 4'd1, 32'h11);
      clear_all();
      cyc("ena_end", 3'b000, 4'd2, 32'h22);
      // Requesters 0 and 2 alternate, pointer 2
      set_req(0, 1'b1, 4'd8, 32'h80);
      set_req(2, 1'b1, 4'd9, 32'h90);
      isjump[2] = 1'b1;
      jaddr[2*DW +: DW] = 32'h1234;
      cyc("bp0", 3'b100, 4'd0, 32'h0);
      chk("bp.isjump", 32'(cdb_isjump), 32'h1);
      chk("bp.jaddr", cdb_jaddr, 32'h1234);
      cyc("bp1", 3'b001, 4'd9, 32'h90);
      chk("bp.isjump0", 32'(cdb_isjump), 32'h0);
      cyc("bp2", 3'b100, 4'd8, 32'h80);
      cyc("bp3", 3'b001, 4'd9, 32'h90);
      clear_all();
      cyc("bp_end", 3'b000, 4'd8, 32'h80);
      cyc("idle", 3'b000, 4'd0, 32'h0);
      chk("isload", 32'(cdb_isload), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
